// File: rtl/interlaken_pkg.sv
`default_nettype none
// ============================================================
// interlaken_pkg : shared 64B/67B constants, header codes, popcount
// Rev 1.0
// ============================================================
package interlaken_pkg;

   localparam int WORD_W    = 67;
   localparam int PAYLOAD_W = 64;
   localparam int GEAR_W    = 80;
   localparam int ACC_W     = 146;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   function automatic logic [6:0] popcount64(input logic [PAYLOAD_W-1:0] d);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < PAYLOAD_W; i++) begin
         n = n + 7'(d[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gearbox_67_80.sv
`default_nettype none
// ============================================================
// gearbox_67_80 : packs 67-bit code words LSB-first into 80-bit beats
// Rev 1.0
// ============================================================
module gearbox_67_80
   import interlaken_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clear,
   input  logic [PAYLOAD_W+1:0] i_byp_word,
   input  logic                 i_byp_vld,
   input  logic [WORD_W-1:0]    i_cw,
   input  logic                 i_cw_vld,
   output logic [GEAR_W-1:0]    o_data,
   output logic                 o_data_vld
);

   logic [ACC_W-1:0]  r_acc;
   logic [6:0]        r_fill;
   logic [GEAR_W-1:0] r_data;
   logic              r_data_vld;

   logic [ACC_W-1:0]  w_cw_sh;
   logic [ACC_W-1:0]  w_acc;
   logic [7:0]        w_new;
   logic              w_emit;

   // Bits at and above r_fill are always zero, so OR-ing in the new word is a write.
   assign w_cw_sh = i_cw_vld ? (ACC_W'(i_cw) << r_fill) : '0;
   assign w_acc   = r_acc | w_cw_sh;
   assign w_new   = {1'b0, r_fill} + (i_cw_vld ? 8'(WORD_W) : 8'd0);
   assign w_emit  = (w_new >= 8'(GEAR_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_fill     <= '0;
         r_data     <= '0;
         r_data_vld <= 1'b0;
      end else if (i_clear) begin
         r_acc      <= '0;
         r_fill     <= '0;
         r_data     <= GEAR_W'(i_byp_word);
         r_data_vld <= i_byp_vld;
      end else if (w_emit) begin
         r_acc      <= w_acc >> GEAR_W;
         r_fill     <= 7'(w_new - 8'(GEAR_W));
         r_data     <= w_acc[GEAR_W-1:0];
         r_data_vld <= 1'b1;
      end else begin
         r_acc      <= w_acc;
         r_fill     <= w_new[6:0];
         r_data_vld <= 1'b0;
      end
   end

   assign o_data     = r_data;
   assign o_data_vld = r_data_vld;

endmodule
`default_nettype wire

// File: rtl/encode_64b_67b.sv
`default_nettype none
// ============================================================
// encode_64b_67b : Interlaken TX 64B/67B encoder with 67->80 gearbox
// Rev 1.0
// ============================================================
module encode_64b_67b
   import interlaken_pkg::*;
#(
   parameter int DISP_W    = 9,
   parameter int INVERT_EN = 1
)(
   input  logic                     USER_CLK,
   input  logic                     SYSTEM_RESET_N,
   input  logic                     PASSTHROUGH,
   input  logic [PAYLOAD_W-1:0]     DATA_IN,
   input  logic [1:0]               HEADER_IN,
   input  logic                     DATA_VALID_IN,
   output logic [GEAR_W-1:0]        DATA_OUT,
   output logic                     DATA_VALID_OUT,
   output logic signed [DISP_W-1:0] DISPARITY_OUT
);

   localparam logic signed [DISP_W-1:0] c_WORD_W_S = DISP_W'(WORD_W);

   logic signed [DISP_W-1:0] r_rd;
   logic [WORD_W-1:0]        r_cw;
   logic                     r_cw_vld;

   logic [6:0]               w_pc;
   logic [6:0]               w_pay_pc;
   logic [6:0]               w_cw_pc;
   logic                     w_rd_pos;
   logic                     w_rd_neg;
   logic                     w_inv;
   logic signed [DISP_W-1:0] w_delta;

   assign w_pc     = popcount64(DATA_IN);
   assign w_rd_neg = r_rd[DISP_W-1];
   assign w_rd_pos = !r_rd[DISP_W-1] && (r_rd != '0);
   // Payload disparity sign is popcount vs. 32; zero on either side never inverts.
   assign w_inv    = (INVERT_EN != 0) &&
                     ((w_rd_pos && (w_pc > 7'd32)) || (w_rd_neg && (w_pc < 7'd32)));
   assign w_pay_pc = w_inv ? (7'(PAYLOAD_W) - w_pc) : w_pc;
   assign w_cw_pc  = w_pay_pc + 7'(HEADER_IN[1]) + 7'(HEADER_IN[0]) + 7'(w_inv);
   assign w_delta  = $signed(DISP_W'({w_cw_pc, 1'b0})) - c_WORD_W_S;

   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         r_rd     <= '0;
         r_cw     <= '0;
         r_cw_vld <= 1'b0;
      end else if (PASSTHROUGH) begin
         r_rd     <= '0;
         r_cw_vld <= 1'b0;
      end else if (DATA_VALID_IN) begin
         r_cw     <= {w_inv, HEADER_IN, (w_inv ? ~DATA_IN : DATA_IN)};
         r_rd     <= r_rd + w_delta;
         r_cw_vld <= 1'b1;
      end else begin
         r_cw_vld <= 1'b0;
      end
   end

   gearbox_67_80 u_gearbox (
      .clk        (USER_CLK),
      .rst_n      (SYSTEM_RESET_N),
      .i_clear    (PASSTHROUGH),
      .i_byp_word ({HEADER_IN, DATA_IN}),
      .i_byp_vld  (DATA_VALID_IN),
      .i_cw       (r_cw),
      .i_cw_vld   (r_cw_vld),
      .o_data     (DATA_OUT),
      .o_data_vld (DATA_VALID_OUT)
   );

   assign DISPARITY_OUT = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_encode_64b_67b.sv
`default_nettype none
// ============================================================
// tb_encode_64b_67b : randomized bench against a bit-queue reference model
// Rev 1.0
// ============================================================
module tb_encode_64b_67b;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PASSTHROUGH = 1'b0;
   logic [63:0] DATA_IN = '0;
   logic [1:0]  HEADER_IN = '0;
   logic        DATA_VALID_IN = 1'b0;
   logic [79:0] DATA_OUT;
   logic        DATA_VALID_OUT;
   logic signed [8:0] DISPARITY_OUT;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: code words become a plain bit queue, popped 80 at a time.
   int          m_rd;
   bit          m_pend;
   logic [66:0] m_cw;
   bit          bitq[$];
   logic [79:0] exp_out;
   logic        exp_vld;

   encode_64b_67b #(.DISP_W(9), .INVERT_EN(1)) dut (
      .USER_CLK       (clk),
      .SYSTEM_RESET_N (rst_n),
      .PASSTHROUGH    (PASSTHROUGH),
      .DATA_IN        (DATA_IN),
      .HEADER_IN      (HEADER_IN),
      .DATA_VALID_IN  (DATA_VALID_IN),
      .DATA_OUT       (DATA_OUT),
      .DATA_VALID_OUT (DATA_VALID_OUT),
      .DISPARITY_OUT  (DISPARITY_OUT)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_rd    = 0;
      m_pend  = 0;
      bitq.delete();
      exp_out = '0;
      exp_vld = 1'b0;
   endtask

   task automatic step(input bit vld, input logic [1:0] hdr, input logic [63:0] d, input bit pt);
      int  dp;
      bit  inv;
      DATA_VALID_IN = vld;
      HEADER_IN     = hdr;
      DATA_IN       = d;
      PASSTHROUGH   = pt;
      if (pt) begin
         exp_out = {14'b0, hdr, d};
         exp_vld = vld;
         m_rd    = 0;
         m_pend  = 0;
         bitq.delete();
      end else begin
         if (m_pend) for (int i = 0; i < 67; i++) bitq.push_back(m_cw[i]);
         if (bitq.size() >= 80) begin
            for (int i = 0; i < 80; i++) exp_out[i] = bitq.pop_front();
            exp_vld = 1'b1;
         end else begin
            exp_vld = 1'b0;
         end
         m_pend = vld;
         if (vld) begin
            dp   = 2 * $countones(d) - 64;
            inv  = (m_rd > 0 && dp > 0) || (m_rd < 0 && dp < 0);
            m_cw = {inv, hdr, (inv ? ~d : d)};
            m_rd = m_rd + 2 * $countones(m_cw) - 67;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      DATA_VALID_IN = 1'b0;
      PASSTHROUGH   = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_vec++;
      if (DATA_OUT !== '0 || DATA_VALID_OUT !== 1'b0 || DISPARITY_OUT !== 9'sd0) begin
         n_err++;
         $display("FAIL reset_state: out=%h vld=%b rd=%0d, want all zero", DATA_OUT, DATA_VALID_OUT, DISPARITY_OUT);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_disparity();
      logic [63:0] ones = 64'hFFFF_FFFF_FFFF_FFFF;
      int want_rd[3] = '{63, 0, 63};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(i < 3, 2'b01, ones, 1'b0);
         if (i < 3) begin
            n_vec++;
            if (DISPARITY_OUT !== 9'(want_rd[i])) begin
               n_err++;
               $display("FAIL disp_word%0d: rd=%0d want %0d", i, DISPARITY_OUT, want_rd[i]);
            end
         end
         if (i == 2) begin
            n_vec++;
            if (DATA_VALID_OUT !== 1'b1 || DATA_OUT[66] !== 1'b0 || DATA_OUT[79:67] !== 13'h0) begin
               n_err++;
               $display("FAIL disp_out0: vld=%b out=%h want bit66=0 and cw1[12:0]=0", DATA_VALID_OUT, DATA_OUT);
            end
         end
         if (i == 3) begin
            n_vec++;
            if (DATA_VALID_OUT !== 1'b1 || DATA_OUT[53:51] !== 3'b101 || DATA_OUT[50:0] !== 51'h0
                || DATA_OUT[79:54] !== 26'h3FF_FFFF) begin
               n_err++;
               $display("FAIL disp_out1: vld=%b out=%h want cw1 inv=1 hdr=01 payload 0, cw2 ones", DATA_VALID_OUT, DATA_OUT);
            end
         end
      end
   endtask

   task automatic test_zero_disparity();
      do_reset();
      step(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      step(1'b1, 2'b01, 64'h5555_5555_5555_5555, 1'b0);
      n_vec++;
      if (DISPARITY_OUT !== 9'sd62) begin
         n_err++;
         $display("FAIL zero_disp: rd=%0d want 62", DISPARITY_OUT);
      end
      step(1'b0, 2'b00, 64'h0, 1'b0);
      n_vec++;
      if (DATA_OUT[79:67] !== 13'h1555) begin
         n_err++;
         $display("FAIL zero_disp_payload: out[79:67]=%h want 1555 (not inverted)", DATA_OUT[79:67]);
      end
   endtask

   task automatic test_gearbox_ratio();
      logic [66:0] cw = {1'b0, 2'b10, 64'h0123_4567_89AB_CDEF};
      int pulses = 0;
      int first  = -1;
      do_reset();
      for (int i = 0; i < 84; i++) begin
         step(i < 80, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0);
         if (DATA_VALID_OUT === 1'b1) begin
            pulses++;
            if (first < 0) begin
               first = i;
               n_vec++;
               if (DATA_OUT[66:0] !== cw || DATA_OUT[79:67] !== cw[12:0]) begin
                  n_err++;
                  $display("FAIL ratio_first_word: out=%h want cw0 + cw1[12:0]", DATA_OUT);
               end
            end
         end
         n_vec++;
         if (DATA_VALID_OUT !== exp_vld || DATA_OUT !== exp_out || DISPARITY_OUT !== 9'(m_rd)) begin
            n_err++;
            $display("FAIL ratio_cycle%0d: vld=%b out=%h rd=%0d want vld=%b out=%h rd=%0d",
                     i, DATA_VALID_OUT, DATA_OUT, DISPARITY_OUT, exp_vld, exp_out, m_rd);
         end
      end
      n_vec++;
      if (pulses != 67 || first != 2) begin
         n_err++;
         $display("FAIL ratio_count: pulses=%0d first=%0d want 67 and 2", pulses, first);
      end
      n_vec++;
      if (DISPARITY_OUT !== -9'sd80) begin
         n_err++;
         $display("FAIL ratio_disp: rd=%0d want -80", DISPARITY_OUT);
      end
   endtask

   task automatic test_gapped();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 164; i++) begin
         step((i < 160) && (i % 2 == 0), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, rnd64(), 1'b0);
         if (DATA_VALID_OUT === 1'b1) pulses++;
         n_vec++;
         if (DATA_VALID_OUT !== exp_vld || DATA_OUT !== exp_out || DISPARITY_OUT !== 9'(m_rd)) begin
            n_err++;
            $display("FAIL gapped_cycle%0d: vld=%b out=%h rd=%0d want vld=%b out=%h rd=%0d",
                     i, DATA_VALID_OUT, DATA_OUT, DISPARITY_OUT, exp_vld, exp_out, m_rd);
         end
      end
      n_vec++;
      if (pulses != 67) begin
         n_err++;
         $display("FAIL gapped_count: pulses=%0d want 67", pulses);
      end
   endtask

   task automatic test_passthrough();
      logic [63:0] d;
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 2'b01, rnd64(), 1'b0);
      d = rnd64();
      step(1'b1, 2'b10, d, 1'b1);
      n_vec++;
      if (DATA_OUT !== {14'b0, 2'b10, d} || DATA_VALID_OUT !== 1'b1 || DISPARITY_OUT !== 9'sd0) begin
         n_err++;
         $display("FAIL passthrough: out=%h vld=%b rd=%0d want %h 1 0", DATA_OUT, DATA_VALID_OUT,
                  DISPARITY_OUT, {14'b0, 2'b10, d});
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, rnd64(), 1'b0);
         n_vec++;
         if (DATA_VALID_OUT !== exp_vld || DATA_OUT !== exp_out || DISPARITY_OUT !== 9'(m_rd)) begin
            n_err++;
            $display("FAIL pt_restart%0d: vld=%b out=%h rd=%0d want vld=%b out=%h rd=%0d",
                     i, DATA_VALID_OUT, DATA_OUT, DISPARITY_OUT, exp_vld, exp_out, m_rd);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [66:0] cw_a = {1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF};
      do_reset();
      step(1'b1, 2'b01, rnd64(), 1'b0);
      step(1'b1, 2'b10, rnd64(), 1'b0);
      step(1'b0, 2'b00, 64'h0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (DATA_OUT !== '0 || DATA_VALID_OUT !== 1'b0 || DISPARITY_OUT !== 9'sd0) begin
         n_err++;
         $display("FAIL async_reset: out=%h vld=%b rd=%0d want all zero", DATA_OUT, DATA_VALID_OUT, DISPARITY_OUT);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         step(i < 2, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
         if (i == 2) begin
            n_vec++;
            if (DATA_VALID_OUT !== 1'b1 || DATA_OUT[66:0] !== cw_a) begin
               n_err++;
               $display("FAIL async_restart_bit0: vld=%b out[66:0]=%h want %h", DATA_VALID_OUT, DATA_OUT[66:0], cw_a);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, (i % 2 == 0) ? 2'b01 : 2'b10,
              ($urandom_range(0, 3) == 0) ? {32'h0, $urandom} : rnd64(),
              $urandom_range(0, 59) == 0);
         n_vec++;
         if (DATA_VALID_OUT !== exp_vld || DATA_OUT !== exp_out || DISPARITY_OUT !== 9'(m_rd)) begin
            n_err++;
            $display("FAIL random_cycle%0d: vld=%b out=%h rd=%0d want vld=%b out=%h rd=%0d",
                     i, DATA_VALID_OUT, DATA_OUT, DISPARITY_OUT, exp_vld, exp_out, m_rd);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_disparity();
      test_zero_disparity();
      test_gearbox_ratio();
      test_gapped();
      test_passthrough();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
